instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Program builder: the encode-side counterpart of the instruction decoder. It takes a stream of symbolic commands (opcode plus operand indices or a jump target) over a valid/ready handshake and packs each one into the 32-bit instruction format. It writes the packed words sequentially into instruction memory from address 0. It terminates the program with a done word, tracks a loop mark for backward jumps, and flags overflow of instruction memory.

Parameters:
INDEX_BIT, default `INDEX_BIT (4), matrix/register index width
INSTR_BIT, default `INSTR_BIT (8), instruction address width; memory depth = 2**INSTR_BIT

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  pulse; clears address and flags, begins a new program
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  3  opcode: 000-101 arithmetic, 110 jump, 111 done
cmd_r1  input  INDEX_BIT  read1 index
cmd_r2  input  INDEX_BIT  read2 index
cmd_wr  input  INDEX_BIT  write index
cmd_jaddr  input  INSTR_BIT  explicit jump target
cmd_use_mark  input  1  jump target is the marked address instead of cmd_jaddr
mark  input  1  latch the current write address as the loop mark
finish  input  1  pulse; append a done word and terminate
mem_we  output  1  instruction memory write enable
mem_addr  output  INSTR_BIT  write address
mem_wdata  output  32  encoded instruction
busy  output  1  high in RUN or TERM
complete  output  1  high in FINISHED
overflow  output  1  sticky; a command was offered while full
instr_count  output  INSTR_BIT+1  words written this program, done word included

Behaviour:
- Encoding:
  - opcode goes to [31:29].
  - Arithmetic: r1 at [28:29-INDEX_BIT], r2 at [28-INDEX_BIT:29-2*INDEX_BIT], wr at [28-2*INDEX_BIT:29-3*INDEX_BIT]; all lower bits 0.
  - Jump: target at [28:29-INSTR_BIT]; all lower bits 0.
  - Done: 0xE0000000.
- Reset: state IDLE; addr = 0; mark_addr = 0; all outputs 0.
- States and transitions:
  - IDLE: cmd_ready = 0. start moves to RUN with addr = 0 and count = 0.
  - RUN: cmd_ready = 1 while addr < 2**INSTR_BIT-1; the last address is reserved for the done word.
    - Accepted command, op != 111: mem_we = 1 next cycle with the registered addr and word; addr and count increment.
    - Accepted op 111, or finish: go to TERM.
  - TERM: one cycle; write the done word at the current addr; count increments; go to FINISHED.
  - FINISHED: complete = 1, cmd_ready = 0, held until start or rst.
- Latency and throughput:
  - Outputs are registered; a handshake in cycle N gives mem_we in cycle N+1.
  - One command per cycle sustained.
  - mem_we is low in every cycle without a write.
- Simultaneous events:
  - finish in the same cycle as an accepted non-done command: the command is written first, and the done word is written the following cycle (TERM).
  - Accepted op 111 with finish also high: exactly one done word is written.
- Mark:
  - mark in RUN sets mark_addr to the current addr, i.e. the address the command accepted this cycle will occupy.
  - mark outside RUN is ignored.
  - A jump with cmd_use_mark = 1 in the same cycle as mark uses the new value.
- Full:
  - At addr = 2**INSTR_BIT-1, cmd_ready = 0.
  - cmd_valid high while full sets overflow (sticky).
  - finish is still honoured, so the done word lands in the last slot.
- start in any state, including RUN or TERM mid-program: restart next cycle. No write is issued that cycle; addr, count, overflow and complete are cleared. Memory is not cleared.
- rst mid-operation: return to reset values and drop any pending write.

Decomposition:
- Shared constants package / CONSTANT.v holds:
  - INDEX_BIT and INSTR_BIT;
  - opcode constants OP_JUMP = 3'b110 and OP_DONE = 3'b111;
  - field bit positions, shared with the decoder so the two cannot diverge.
- One natural sub-module: instr_pack, combinational packing of op/indices/target into 32 bits. The FSM, counters and mark register stay in instr_encoder.

Test Plan:
(INDEX_BIT = 4, INSTR_BIT = 8)
1. start, then op 010 r1=3 r2=5 wr=7 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x46AE0000; instr_count=1.
2. Three back-to-back commands, then finish -> writes at addr 0,1,2 in consecutive cycles; done 0xE0000000 at addr 3; complete=1; instr_count=4; cmd_ready=0.
3. mark together with the command at addr 2; later jump with cmd_use_mark=1 -> jump word 0xC0400000. Explicit jump to 5 -> 0xC0A00000.
4. finish in the same cycle as an accepted command -> command at addr N, done at N+1 on the next cycle, no duplicate done.
5. Fill 255 words -> cmd_ready drops at addr 255; offering cmd_valid sets overflow; finish writes done at 255; instr_count=256.
6. start asserted in RUN after 4 writes -> no write that cycle; next command goes to addr 0; overflow/complete cleared. rst mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder/decoder pair: widths, opcodes and
// field positions of the 32-bit instruction word.
package instr_encoder_pkg;

    localparam int unsigned INDEX_BIT = 4;
    localparam int unsigned INSTR_BIT = 8;
    localparam int unsigned WORD_BIT  = 32;
    localparam int unsigned OP_BIT    = 3;

    // Opcode sits on top; operand fields are packed downward from FIELD_MSB.
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 29;
    localparam int unsigned FIELD_MSB = 28;

    localparam logic [OP_BIT-1:0]   OP_JUMP   = 3'b110;
    localparam logic [OP_BIT-1:0]   OP_DONE   = 3'b111;
    localparam logic [WORD_BIT-1:0] DONE_WORD = 32'hE000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TERM,
        ST_FINISHED
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of one symbolic command into a 32-bit instruction word.
module instr_pack #(
    parameter int unsigned INDEX_BIT = instr_encoder_pkg::INDEX_BIT,
    parameter int unsigned INSTR_BIT = instr_encoder_pkg::INSTR_BIT
) (
    input  logic [2:0]           i_op,
    input  logic [INDEX_BIT-1:0] i_r1,
    input  logic [INDEX_BIT-1:0] i_r2,
    input  logic [INDEX_BIT-1:0] i_wr,
    input  logic [INSTR_BIT-1:0] i_jaddr,
    output logic [31:0]          o_word_c
);
    import instr_encoder_pkg::*;

    localparam int unsigned R1_LSB = FIELD_MSB + 1 - INDEX_BIT;
    localparam int unsigned R2_MSB = R1_LSB - 1;
    localparam int unsigned R2_LSB = R2_MSB + 1 - INDEX_BIT;
    localparam int unsigned WR_MSB = R2_LSB - 1;
    localparam int unsigned WR_LSB = WR_MSB + 1 - INDEX_BIT;
    localparam int unsigned JA_LSB = FIELD_MSB + 1 - INSTR_BIT;

    always_comb begin
        o_word_c = '0;
        o_word_c[OP_MSB:OP_LSB] = i_op;
        if (i_op == OP_DONE) begin
            o_word_c = DONE_WORD;
        end else if (i_op == OP_JUMP) begin
            o_word_c[FIELD_MSB:JA_LSB] = i_jaddr;
        end else begin
            o_word_c[FIELD_MSB:R1_LSB] = i_r1;
            o_word_c[R2_MSB:R2_LSB]    = i_r2;
            o_word_c[WR_MSB:WR_LSB]    = i_wr;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program builder: accepts symbolic commands, packs them and writes them
// sequentially into instruction memory, terminating with a done word.
module instr_encoder #(
    parameter int unsigned INDEX_BIT = instr_encoder_pkg::INDEX_BIT,
    parameter int unsigned INSTR_BIT = instr_encoder_pkg::INSTR_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [INDEX_BIT-1:0] cmd_r1,
    input  logic [INDEX_BIT-1:0] cmd_r2,
    input  logic [INDEX_BIT-1:0] cmd_wr,
    input  logic [INSTR_BIT-1:0] cmd_jaddr,
    input  logic                 cmd_use_mark,
    input  logic                 mark,
    input  logic                 finish,
    output logic                 mem_we,
    output logic [INSTR_BIT-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 busy,
    output logic                 complete,
    output logic                 overflow,
    output logic [INSTR_BIT:0]   instr_count
);
    import instr_encoder_pkg::*;

    // Last slot is reserved for the done word.
    localparam logic [INSTR_BIT-1:0] LAST_ADDR = '1;

    state_t               r_state,    w_state_nxt;
    logic [INSTR_BIT-1:0] r_addr,     w_addr_nxt;
    logic [INSTR_BIT:0]   r_count,    w_count_nxt;
    logic [INSTR_BIT-1:0] r_mark,     w_mark_nxt;
    logic                 r_we,       w_we_nxt;
    logic [INSTR_BIT-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0]          r_wdata,    w_wdata_nxt;
    logic                 r_overflow, w_overflow_nxt;
    logic                 r_ready,    w_ready_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_complete, w_complete_nxt;

    logic                 w_full;
    logic                 w_accept;
    logic [INSTR_BIT-1:0] w_mark_eff;
    logic [INSTR_BIT-1:0] w_jaddr;
    logic [31:0]          w_word;

    assign w_full     = (r_addr == LAST_ADDR);
    assign w_accept   = cmd_valid & r_ready;
    // A mark raised this cycle is visible to a jump in the same cycle.
    assign w_mark_eff = ((r_state == ST_RUN) && mark) ? r_addr : r_mark;
    assign w_jaddr    = cmd_use_mark ? w_mark_eff : cmd_jaddr;

    instr_pack #(
        .INDEX_BIT (INDEX_BIT),
        .INSTR_BIT (INSTR_BIT)
    ) u_pack (
        .i_op     (cmd_op),
        .i_r1     (cmd_r1),
        .i_r2     (cmd_r2),
        .i_wr     (cmd_wr),
        .i_jaddr  (w_jaddr),
        .o_word_c (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_mark     <= '0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_count    <= w_count_nxt;
            r_mark     <= w_mark_nxt;
            r_we       <= w_we_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_overflow <= w_overflow_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_complete <= w_complete_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_count_nxt    = r_count;
        w_mark_nxt     = r_mark;
        w_we_nxt       = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_wdata_nxt    = r_wdata;
        w_overflow_nxt = r_overflow;

        if (start) begin
            // Restart from any state; memory contents are left as they are.
            w_state_nxt    = ST_RUN;
            w_addr_nxt     = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_mark_nxt = w_mark_eff;
                    if (cmd_valid && w_full) begin
                        w_overflow_nxt = 1'b1;
                    end
                    if (w_accept && (cmd_op != OP_DONE)) begin
                        w_we_nxt       = 1'b1;
                        w_mem_addr_nxt = r_addr;
                        w_wdata_nxt    = w_word;
                        w_addr_nxt     = r_addr + INSTR_BIT'(1);
                        w_count_nxt    = r_count + (INSTR_BIT+1)'(1);
                    end
                    if ((w_accept && (cmd_op == OP_DONE)) || finish) begin
                        w_state_nxt = ST_TERM;
                    end
                end
                ST_TERM: begin
                    w_we_nxt       = 1'b1;
                    w_mem_addr_nxt = r_addr;
                    w_wdata_nxt    = DONE_WORD;
                    w_count_nxt    = r_count + (INSTR_BIT+1)'(1);
                    w_state_nxt    = ST_FINISHED;
                end
                default: begin
                end
            endcase
        end

        // Status outputs are registered from the next-state view.
        w_ready_nxt    = (w_state_nxt == ST_RUN) && (w_addr_nxt != LAST_ADDR);
        w_busy_nxt     = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_TERM);
        w_complete_nxt = (w_state_nxt == ST_FINISHED);
    end

    assign cmd_ready   = r_ready;
    assign mem_we      = r_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = r_busy;
    assign complete    = r_complete;
    assign overflow    = r_overflow;
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table plus multi-cycle
// sequences, with a scoreboard queue of expected memory writes.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_r1;
    logic [3:0]  cmd_r2;
    logic [3:0]  cmd_wr;
    logic [7:0]  cmd_jaddr;
    logic        cmd_use_mark;
    logic        mark;
    logic        finish;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        complete;
    logic        overflow;
    logic [8:0]  instr_count;

    always #5 clk = ~clk;

    instr_encoder #(.INDEX_BIT(4), .INSTR_BIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_r1       (cmd_r1),
        .cmd_r2       (cmd_r2),
        .cmd_wr       (cmd_wr),
        .cmd_jaddr    (cmd_jaddr),
        .cmd_use_mark (cmd_use_mark),
        .mark         (mark),
        .finish       (finish),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .complete     (complete),
        .overflow     (overflow),
        .instr_count  (instr_count)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_wr_t;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  wr;
        logic [7:0]  ja;
        logic [31:0] exp;
    } vec_t;

    exp_wr_t    exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_addr;
    logic [8:0] m_count;

    function automatic logic [31:0] model_word(input logic [2:0] op, input logic [3:0] r1,
                                               input logic [3:0] r2, input logic [3:0] wr,
                                               input logic [7:0] ja);
        if (op == 3'b111) return 32'hE000_0000;
        if (op == 3'b110) return {op, ja, 21'd0};
        return {op, r1, r2, wr, 17'd0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock, then check any write against the scoreboard.
    task automatic tick();
        exp_wr_t e;
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [31:0] d);
        exp_wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic term_tail();
        push_exp(m_addr, 32'hE000_0000);
        m_count++;
        tick();
        chk("done_count", 64'(instr_count), 64'(m_count));
        chk("complete", 64'(complete), 64'd1);
        chk("ready_done", 64'(cmd_ready), 64'd0);
        chk("busy_done", 64'(busy), 64'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_addr  = '0;
        m_count = '0;
        chk("start_count", 64'(instr_count), 64'd0);
        chk("start_ready", 64'(cmd_ready), 64'd1);
        chk("start_ovf", 64'(overflow), 64'd0);
        chk("start_cmpl", 64'(complete), 64'd0);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] wr, input logic [7:0] ja, input logic um,
                       input logic mk, input logic fin, input logic [31:0] exp);
        cmd_valid = 1'b1; cmd_op = op; cmd_r1 = r1; cmd_r2 = r2; cmd_wr = wr;
        cmd_jaddr = ja; cmd_use_mark = um; mark = mk; finish = fin;
        if (op != 3'b111) begin
            push_exp(m_addr, exp);
            m_addr++;
            m_count++;
        end
        tick();
        cmd_valid = 1'b0; cmd_use_mark = 1'b0; mark = 1'b0; finish = 1'b0;
        chk("instr_count", 64'(instr_count), 64'(m_count));
        if (op == 3'b111 || fin) term_tail();
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        term_tail();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cmpl"}, 64'(complete), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_count"}, 64'(instr_count), 64'd0);
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{3'b010, 4'h3, 4'h5, 4'h7, 8'h00, 32'h46AE_0000};
        tbl[1] = '{3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 32'h0000_0000};
        tbl[2] = '{3'b101, 4'hF, 4'hF, 4'hF, 8'h00, 32'hBFFE_0000};
        tbl[3] = '{3'b001, 4'h1, 4'h2, 4'h3, 8'h00, 32'h2246_0000};
        tbl[4] = '{3'b011, 4'hA, 4'h0, 4'h5, 8'h00, 32'h740A_0000};
        tbl[5] = '{3'b110, 4'h0, 4'h0, 4'h0, 8'h05, 32'hC0A0_0000};
        tbl[6] = '{3'b110, 4'h9, 4'h9, 4'h9, 8'hFF, 32'hDFE0_0000};
        tbl[7] = '{3'b100, 4'h0, 4'h0, 4'h1, 8'h00, 32'h8002_0000};

        rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_r1 = '0;
        cmd_r2 = '0; cmd_wr = '0; cmd_jaddr = '0; cmd_use_mark = 1'b0;
        mark = 1'b0; finish = 1'b0; m_addr = '0; m_count = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(cmd_ready), 64'd0);

        // Encoding table, back to back from address 0.
        do_start();
        for (int i = 0; i < 8; i++) begin
            cmd(tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].wr, tbl[i].ja, 1'b0, 1'b0, 1'b0,
                tbl[i].exp);
        end
        do_finish();
        chk("tbl_count", 64'(instr_count), 64'd9);

        // Three commands then a lone finish.
        do_start();
        for (int i = 0; i < 3; i++) begin
            cmd(3'(i), 4'(i), 4'(i + 1), 4'(i + 2), 8'h00, 1'b0, 1'b0, 1'b0,
                model_word(3'(i), 4'(i), 4'(i + 1), 4'(i + 2), 8'h00));
        end
        do_finish();
        chk("seq2_count", 64'(instr_count), 64'd4);
        tick();
        chk("seq2_hold", 64'(complete), 64'd1);

        // Mark and jumps to the mark / explicit target.
        do_start();
        cmd(3'b000, 4'h1, 4'h1, 4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0222_0000);
        cmd(3'b000, 4'h2, 4'h2, 4'h2, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0444_0000);
        cmd(3'b001, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h2000_0000);
        cmd(3'b010, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
        cmd(3'b110, 4'h0, 4'h0, 4'h0, 8'h77, 1'b1, 1'b0, 1'b0, 32'hC040_0000);
        cmd(3'b110, 4'h0, 4'h0, 4'h0, 8'h05, 1'b0, 1'b0, 1'b0, 32'hC0A0_0000);
        cmd(3'b110, 4'h0, 4'h0, 4'h0, 8'h33, 1'b1, 1'b1, 1'b0, 32'hC0C0_0000);
        do_finish();
        chk("mark_count", 64'(instr_count), 64'd8);

        // finish together with an accepted command; then op 111 with finish.
        do_start();
        cmd(3'b011, 4'h4, 4'h4, 4'h4, 8'h00, 1'b0, 1'b0, 1'b0, 32'h6888_0000);
        cmd(3'b100, 4'h8, 4'h0, 4'h1, 8'h00, 1'b0, 1'b0, 1'b1, 32'h9002_0000);
        tick();
        chk("fin_cmd_count", 64'(instr_count), 64'd3);
        do_start();
        cmd(3'b001, 4'h0, 4'h0, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 32'h201E_0000);
        cmd(3'b111, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        chk("op111_count", 64'(instr_count), 64'd2);

        // Fill memory, overflow, done word in the last slot.
        do_start();
        for (int i = 0; i < 255; i++) begin
            cmd(3'(i % 6), 4'(i), 4'(i >> 4), 4'(~i), 8'(i), 1'b0, 1'b0, 1'b0,
                model_word(3'(i % 6), 4'(i), 4'(i >> 4), 4'(~i), 8'(i)));
        end
        chk("full_ready", 64'(cmd_ready), 64'd0);
        chk("full_ovf_pre", 64'(overflow), 64'd0);
        cmd_valid = 1'b1;
        cmd_op = 3'b010;
        tick();
        cmd_valid = 1'b0;
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_count", 64'(instr_count), 64'd255);
        do_finish();
        chk("full_done_count", 64'(instr_count), 64'd256);
        chk("full_ovf_sticky", 64'(overflow), 64'd1);

        // Restart mid-program, then reset mid-program.
        do_start();
        for (int i = 0; i < 4; i++) begin
            cmd(3'b101, 4'(i), 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0,
                model_word(3'b101, 4'(i), 4'h0, 4'h0, 8'h00));
        end
        cmd_valid = 1'b1;
        cmd_op = 3'b010;
        do_start();
        cmd_valid = 1'b0;
        chk("restart_busy", 64'(busy), 64'd1);
        cmd(3'b010, 4'h3, 4'h5, 4'h7, 8'h00, 1'b0, 1'b0, 1'b0, 32'h46AE_0000);
        cmd(3'b000, 4'h0, 4'h0, 4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0002_0000);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'b001;
        tick();
        cmd_valid = 1'b0;
        chk_idle_outputs("midrst");
        rst = 1'b0;
        tick();
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
